// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : shared opcodes, state encoding and helpers for muldiv_unit
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_step : one combinational restoring-division step (one quotient bit)
// Rev 1.0
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] w_trial;
  logic [XLEN:0] w_diff;

  // rem_i < dvsr_i holds on entry, so the trial fits and the borrow bit alone decides
  assign w_trial = {rem_i, quo_i[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, dvsr_i};

  always_comb begin
    if (!w_diff[XLEN]) begin
      rem_o = w_diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = w_trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : multi-cycle RV32M multiply/divide unit, START/DONE handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_UNROLL = 1,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int ITER    = XLEN / DIV_UNROLL;
  localparam int CNT_MAX = (ITER > MUL_STAGES) ? ITER : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_rem_q, is_rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;

  logic               w_accept;
  logic               w_a_sgn_mul, w_b_sgn_mul;
  logic [2*XLEN-1:0]  w_mul_a, w_mul_b, w_prod;
  logic [XLEN-1:0]    w_mul_res, w_mul_final;
  logic               w_sgn, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_is_rem;
  logic [XLEN-1:0]    w_abs_a, w_abs_b, w_special;
  logic [XLEN-1:0]    w_fix_quo, w_fix_rem;
  logic [DIV_UNROLL:0][XLEN-1:0] w_rem_c, w_quo_c;

  assign w_accept = start && !busy_q && !flush;

  // Multiplier: extend to 2*XLEN so one unsigned product covers every signedness mix
  assign w_a_sgn_mul = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign w_b_sgn_mul = (funct3 == F3_MULH);
  assign w_mul_a     = {{XLEN{w_a_sgn_mul & operand_a[XLEN-1]}}, operand_a};
  assign w_mul_b     = {{XLEN{w_b_sgn_mul & operand_b[XLEN-1]}}, operand_b};
  assign w_prod      = w_mul_a * w_mul_b;
  assign w_mul_res   = (funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  generate
    if (MUL_STAGES > 1) begin : g_mul_pipe
      logic [MUL_STAGES-2:0][XLEN-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = pipe_q;
        if (w_accept) pipe_d[0] = w_mul_res;
        for (int k = 1; k < MUL_STAGES - 1; k++) pipe_d[k] = pipe_q[k-1];
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pipe_q <= '0;
        else         pipe_q <= pipe_d;
      end

      assign w_mul_final = pipe_q[MUL_STAGES-2];
    end else begin : g_mul_direct
      assign w_mul_final = w_mul_res;
    end
  endgenerate

  // Divider front end: magnitudes, sign flags and the two RISC-V special cases
  assign w_sgn     = is_signed_op(funct3);
  assign w_a_neg   = w_sgn & operand_a[XLEN-1];
  assign w_b_neg   = w_sgn & operand_b[XLEN-1];
  assign w_abs_a   = w_a_neg ? -operand_a : operand_a;
  assign w_abs_b   = w_b_neg ? -operand_b : operand_b;
  assign w_is_rem  = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign w_b_zero  = (operand_b == '0);
  assign w_ovf     = w_sgn && (operand_a == MIN_VAL) && (operand_b == '1);
  assign w_special = w_b_zero ? (w_is_rem ? operand_a : '1)
                              : (w_is_rem ? '0 : MIN_VAL);

  assign w_rem_c[0] = rem_q;
  assign w_quo_c[0] = quo_q;

  generate
    for (genvar i = 0; i < DIV_UNROLL; i++) begin : g_div_chain
      div_step #(
        .XLEN   (XLEN)
      ) u_div_step (
        .rem_i  (w_rem_c[i]),
        .quo_i  (w_quo_c[i]),
        .dvsr_i (dvsr_q),
        .rem_o  (w_rem_c[i+1]),
        .quo_o  (w_quo_c[i+1])
      );
    end
  endgenerate

  assign w_fix_quo = neg_quo_q ? -quo_q : quo_q;
  assign w_fix_rem = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    tag_d     = tag_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          state_d = S_IDLE;
          if (w_accept) begin
            tag_d = tag_in;
            if (!funct3[2]) begin
              if (MUL_STAGES == 1) begin
                result_d  = w_mul_final;
                tag_out_d = tag_in;
                state_d   = S_FIN;
              end else begin
                cnt_d   = CNT_W'(MUL_STAGES - 2);
                state_d = S_MUL;
              end
            end else if (w_b_zero || w_ovf) begin
              result_d  = w_special;
              tag_out_d = tag_in;
              state_d   = S_FIN;
            end else begin
              quo_d     = w_abs_a;
              rem_d     = '0;
              dvsr_d    = w_abs_b;
              cnt_d     = CNT_W'(ITER - 1);
              is_rem_d  = w_is_rem;
              neg_quo_d = w_a_neg ^ w_b_neg;
              neg_rem_d = w_a_neg;
              state_d   = S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            result_d  = w_mul_final;
            tag_out_d = tag_q;
            state_d   = S_FIN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          quo_d = w_quo_c[DIV_UNROLL];
          rem_d = w_rem_c[DIV_UNROLL];
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          result_d  = is_rem_q ? w_fix_rem : w_fix_quo;
          tag_out_d = tag_q;
          state_d   = S_FIN;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
      tag_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
      tag_q     <= tag_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign tag_out = tag_out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : randomized self-checking bench for muldiv_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int MUL_STAGES = 2;
  localparam int DIV_UNROLL = 1;
  localparam int DIV_LAT    = XLEN / DIV_UNROLL + 2;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       funct3 = 3'd0;
  logic [XLEN-1:0]  operand_a = '0;
  logic [XLEN-1:0]  operand_b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             busy, done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES),
    .DIV_UNROLL (DIV_UNROLL),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .tag_in    (tag_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .tag_out   (tag_out)
  );

  // Reference: RV32M semantics in 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return MUL_STAGES;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN32;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one request and waits for DONE; returns timing and outputs (lat = -1 on timeout)
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output int lat, output logic [31:0] res,
                       output logic [4:0] tout);
    funct3 = f3; operand_a = a; operand_b = b; tag_in = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; tag_in = 5'($urandom); funct3 = 3'($urandom);
    lat = -1; res = '0; tout = '0;
    for (int k = 1; k <= DIV_LAT + 10; k++) begin
      if (done) begin
        lat = k; res = result; tout = tag_out;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== '0)  begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (tag_out !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_out); end
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [13] = '{32'd7, MIN32, MIN32, MIN32, -32'd7, -32'd7, 32'd100, 32'd55, 32'd12345,
                             MIN32, MIN32, 32'd9, 32'd77};
    logic [31:0] bs  [13] = '{-32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    int lat; logic [31:0] res; logic [4:0] tout; logic [4:0] t;
    for (int i = 0; i < 13; i++) begin
      t = 5'(i + 1);
      do_op(f3s[i], as[i], bs[i], t, lat, res, tout);
      checks++;
      if (res !== ref_result(f3s[i], as[i], bs[i])) begin
        errors++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, ref_result(f3s[i], as[i], bs[i]));
      end
      checks++;
      if (lat != ref_latency(f3s[i], as[i], bs[i])) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, ref_latency(f3s[i], as[i], bs[i]));
      end
      checks++;
      if (tout !== t) begin errors++; $display("FAIL directed_tag[%0d]: got %h want %h", i, tout, t); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL directed_done_pulse[%0d]: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b; logic [4:0] tout, t; logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom); a = pick(); b = pick(); t = 5'($urandom);
      do_op(f3, a, b, t, lat, res, tout);
      checks++;
      if (res !== ref_result(f3, a, b)) begin
        errors++; $display("FAIL random_result[%0d] f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, ref_result(f3, a, b));
      end
      checks++;
      if (lat != ref_latency(f3, a, b)) begin
        errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, ref_latency(f3, a, b));
      end
      checks++;
      if (tout !== t) begin errors++; $display("FAIL random_tag[%0d]: got %h want %h", i, tout, t); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_busy_ignore();
    int lat = -1; logic [31:0] res = '0; logic [4:0] tout = '0;
    funct3 = 3'd5; operand_a = 32'd1000; operand_b = 32'd7; tag_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd0; operand_a = 32'd5; operand_b = 32'd5; tag_in = 5'd9;
    for (int k = 1; k <= DIV_LAT + 10; k++) begin
      if (k == 11) start = 1'b0;
      if (done) begin lat = k; res = result; tout = tag_out; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (res !== 32'd142) begin errors++; $display("FAIL busy_ignore_result: got %h want %h", res, 32'd142); end
    checks++; if (tout !== 5'd3)   begin errors++; $display("FAIL busy_ignore_tag: got %h want 03", tout); end
    checks++; if (lat != DIV_LAT)  begin errors++; $display("FAIL busy_ignore_latency: got %0d want %0d", lat, DIV_LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] prev; int dones = 0; int busies = 0;
    prev = result;
    funct3 = 3'd4; operand_a = 32'd999; operand_b = 32'd4; tag_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd6; operand_a = 32'd50; operand_b = 32'd3; tag_in = 5'd18;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      if (busy) busies++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0)     begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    checks++; if (busies != 0)    begin errors++; $display("FAIL flush_held_start: got %0d busy cycles want 0", busies); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_kept: got %h want %h", result, prev); end
    funct3 = 3'd1; operand_a = 32'd3; operand_b = 32'd3; tag_in = 5'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    dones = 0; busies = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) dones++;
      if (busy) busies++;
      @(posedge clk); #1;
    end
    checks++; if (dones + busies != 0) begin errors++; $display("FAIL flush_same_cycle_start: got %0d activity want 0", dones + busies); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s [6] = '{3'd0, 3'd6, 3'd4, 3'd3, 3'd7, 3'd2};
    logic [31:0] as  [6] = '{32'h1234_5678, -32'd100, 32'd5, 32'hDEAD_BEEF, 32'd1000, -32'd2};
    logic [31:0] bs  [6] = '{32'd16, 32'd7, 32'd0, 32'hCAFE_F00D, 32'd33, 32'd3};
    int lat; logic [31:0] res; logic [4:0] tout;
    for (int i = 0; i < 6; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'(20 + i), lat, res, tout);
      checks++;
      if (res !== ref_result(f3s[i], as[i], bs[i]) || tout !== 5'(20 + i) || lat != ref_latency(f3s[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got res=%h tag=%h lat=%0d want res=%h tag=%h lat=%0d", i, res, tout, lat,
                 ref_result(f3s[i], as[i], bs[i]), 5'(20 + i), ref_latency(f3s[i], as[i], bs[i]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic [4:0] tout; int dones = 0;
    do_op(3'd0, 32'd7, -32'd3, 5'd21, lat, res, tout);
    funct3 = 3'd4; operand_a = 32'd12345; operand_b = 32'd6; tag_in = 5'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || tag_out !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h tag=%h want all 0", busy, done, result, tag_out);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones); end
    do_op(3'd3, MIN32, 32'hFFFF_FFFF, 5'd30, lat, res, tout);
    checks++;
    if (res !== ref_result(3'd3, MIN32, 32'hFFFF_FFFF) || tout !== 5'd30) begin
      errors++; $display("FAIL reset_mid_recover: got %h/%h want %h/1e", res, tout, ref_result(3'd3, MIN32, 32'hFFFF_FFFF));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
